// File: rtl/innings_sequencer.sv
// Cricket match controller: sequences each delivery, tallies runs one pulse at a time, tracks overs/innings and the winner.
// Optional build macro STRIKE_EARLY_MISS_EN: a strike in FLIGHT turns the delivery into a dot ball.
module innings_sequencer #(
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_OVERS      = 5,
    parameter int STRIKE_WINDOW  = 50,
    parameter int TALLY_GAP      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       strike,
    input  logic       ball_arrived,
    input  logic [2:0] zone,
    output logic       launch,
    output logic       run_pulse,
    output logic       innings,
    output logic [3:0] ball,
    output logic [3:0] over,
    output logic [8:0] score_a,
    output logic [8:0] score_b,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [2:0] state
);
    localparam int TW = (STRIKE_WINDOW > 1) ? $clog2(STRIKE_WINDOW) : 1;
    localparam int GW = (TALLY_GAP > 1) ? $clog2(TALLY_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOWL   = 3'd1,
        S_FLIGHT = 3'd2,
        S_WINDOW = 3'd3,
        S_TALLY  = 3'd4,
        S_NEXT   = 3'd5,
        S_BREAK  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic            strike_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [2:0]      pending_q, pending_d;
    logic            out_q, out_d;
    logic [3:0]      ball_q, ball_d;
    logic [3:0]      over_q, over_d;
    logic            innings_q, innings_d;
    logic [8:0]      score_a_q, score_a_d;
    logic [8:0]      score_b_q, score_b_d;
    logic [1:0]      winner_q, winner_d;
    logic            strike_edge;
    logic            end_innings;
    logic [8:0]      bat_score;
    logic [8:0]      bat_inc;
    logic [3:0]      ball_inc;
    logic [3:0]      over_inc;
`ifdef STRIKE_EARLY_MISS_EN
    logic            early_q, early_d;
`endif

    // Zone codes 3 and 5 are unused by the detector and score nothing.
    function automatic logic [2:0] zone_runs(input logic [2:0] z);
        case (z)
            3'd1:    zone_runs = 3'd1;
            3'd2:    zone_runs = 3'd2;
            3'd4:    zone_runs = 3'd4;
            3'd6:    zone_runs = 3'd6;
            default: zone_runs = 3'd0;
        endcase
    endfunction

    always_comb begin
        strike_edge = strike & ~strike_q;
        bat_score   = innings_q ? score_b_q : score_a_q;
        bat_inc     = (bat_score == 9'h1FF) ? bat_score : bat_score + 9'd1;
        ball_inc    = ball_q + 4'd1;
        over_inc    = over_q + 4'd1;

        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        pending_d   = pending_q;
        out_d       = out_q;
        ball_d      = ball_q;
        over_d      = over_q;
        innings_d   = innings_q;
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        winner_d    = winner_q;
        run_pulse   = 1'b0;
        end_innings = 1'b0;
`ifdef STRIKE_EARLY_MISS_EN
        early_d     = early_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_BOWL;
            end
            S_BOWL: begin
                state_d = S_FLIGHT;
            end
            S_FLIGHT: begin
`ifdef STRIKE_EARLY_MISS_EN
                if (strike_edge) early_d = 1'b1;
                if (ball_arrived) begin
                    early_d = 1'b0;
                    if (early_q) begin
                        state_d = S_NEXT;
                    end else begin
                        timer_d = TW'(STRIKE_WINDOW - 1);
                        state_d = S_WINDOW;
                    end
                end
`else
                if (ball_arrived) begin
                    timer_d = TW'(STRIKE_WINDOW - 1);
                    state_d = S_WINDOW;
                end
`endif
            end
            S_WINDOW: begin
                // Edge wins over timeout so a strike on the last window cycle still counts.
                if (strike_edge) begin
                    pending_d = zone_runs(zone);
                    out_d     = (zone == 3'd7);
                    gap_d     = '0;
                    state_d   = S_TALLY;
                end else if (timer_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_TALLY: begin
                if (out_q) begin
                    end_innings = 1'b1;
                end else if (pending_q == 3'd0) begin
                    state_d = S_NEXT;
                end else if (gap_q == '0) begin
                    run_pulse = 1'b1;
                    pending_d = pending_q - 3'd1;
                    gap_d     = GW'(TALLY_GAP - 1);
                    if (innings_q) score_b_d = bat_inc;
                    else           score_a_d = bat_inc;
                    // Chase won: leftover runs are dropped.
                    if (innings_q && (bat_inc > score_a_q)) state_d = S_DONE;
                    else if (pending_q == 3'd1)             state_d = S_NEXT;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_NEXT: begin
                if (ball_inc == 4'(BALLS_PER_OVER)) begin
                    ball_d = 4'd0;
                    over_d = over_inc;
                    if (over_inc == 4'(MAX_OVERS)) end_innings = 1'b1;
                    else                           state_d     = S_BOWL;
                end else begin
                    ball_d  = ball_inc;
                    state_d = S_BOWL;
                end
            end
            S_BREAK: begin
                if (start) state_d = S_BOWL;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (end_innings) begin
            if (!innings_q) begin
                ball_d    = 4'd0;
                over_d    = 4'd0;
                innings_d = 1'b1;
                state_d   = S_BREAK;
            end else begin
                state_d = S_DONE;
            end
        end

        // Winner is frozen on DONE entry using the final totals, including a last chase run.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            if (score_a_d > score_b_d)      winner_d = 2'b01;
            else if (score_b_d > score_a_d) winner_d = 2'b10;
            else                            winner_d = 2'b11;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            strike_q  <= 1'b0;
            timer_q   <= '0;
            gap_q     <= '0;
            pending_q <= 3'd0;
            out_q     <= 1'b0;
            ball_q    <= 4'd0;
            over_q    <= 4'd0;
            innings_q <= 1'b0;
            score_a_q <= 9'd0;
            score_b_q <= 9'd0;
            winner_q  <= 2'b00;
`ifdef STRIKE_EARLY_MISS_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            strike_q  <= strike;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            ball_q    <= ball_d;
            over_q    <= over_d;
            innings_q <= innings_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            winner_q  <= winner_d;
`ifdef STRIKE_EARLY_MISS_EN
            early_q   <= early_d;
`endif
        end
    end

    assign launch    = (state_q == S_BOWL);
    assign innings   = innings_q;
    assign ball      = ball_q;
    assign over      = over_q;
    assign score_a   = score_a_q;
    assign score_b   = score_b_q;
    assign winner    = winner_q;
    assign game_over = (state_q == S_DONE);
    assign state     = state_q;

endmodule
